// File: rtl/ram_burst_reader.sv
// ram_burst_reader: read-side DMA stage on the ram word port.
// On an accepted start it reads len consecutive words from base_addr (wrapping
// modulo RAM_SIZE), absorbs the ram's one-cycle registered read latency and
// presents the words as a valid/ready stream with a last flag.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, base_addr, len burst command (sampled in idle only; len 0 is legal)
//   busy, done            burst in progress / one-cycle completion pulse
//   ram_address, ram_we,  registered ram word address; write side tied off
//   ram_wr_data
//   ram_rd_data           ram read data, valid one edge after address sampled
//   m_valid, m_data,      output stream; m_last marks the final word
//   m_last, m_ready
module ram_burst_reader #(
  parameter int unsigned RAM_SIZE   = 1024,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [31:0]      ram_address,
  output logic             ram_we,
  output logic [31:0]      ram_wr_data,
  input  logic [31:0]      ram_rd_data,
  output logic             m_valid,
  output logic [31:0]      m_data,
  output logic             m_last,
  input  logic             m_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] AddrMask = 32'(RAM_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] popped_q, popped_d;
  logic [31:0]      addr_q, addr_d;
  logic             done_q, done_d;
  logic             issue;

  // flight_q[0]: read sitting in the address register; flight_q[1]: read whose
  // data is on ram_rd_data this cycle.
  logic [1:0]       flight_q;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  logic             push, pop, can_issue;
  logic [CntW:0]    occupancy;

  assign push = flight_q[1];
  assign pop  = m_valid & m_ready;

  // Words already committed to the FIFO (stored or in flight), less the one
  // leaving this cycle; a new read is allowed only if it still has a slot.
  assign occupancy = {1'b0, count_q} + (CntW + 1)'(flight_q[0]) + (CntW + 1)'(flight_q[1])
                     - (CntW + 1)'(pop);
  assign can_issue = occupancy < (CntW + 1)'(FIFO_DEPTH);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q;
    addr_d   = addr_q;
    done_d   = 1'b0;
    issue    = 1'b0;

    if (pop) begin
      popped_d = popped_q + LEN_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d   = base_addr;
          len_d    = len;
          issued_d = '0;
          popped_d = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            // First read goes out on the accepting edge itself.
            issue    = 1'b1;
            addr_d   = base_addr & AddrMask;
            issued_d = LEN_W'(1);
            state_d  = (len == LEN_W'(1)) ? StDrain : StRun;
          end
        end
      end
      StRun: begin
        if (can_issue) begin
          issue    = 1'b1;
          addr_d   = (base_q + 32'(issued_q)) & AddrMask;
          issued_d = issued_q + LEN_W'(1);
          if (issued_q + LEN_W'(1) == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Final pop implies every issued read has already landed.
        if (pop && (popped_q == len_q - LEN_W'(1))) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
      flight_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      flight_q <= {flight_q[0], issue};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= ram_rd_data;
        wr_ptr_q <= (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign ram_address = addr_q;
  assign ram_we      = 1'b0;
  assign ram_wr_data = '0;
  assign m_valid     = (count_q != '0);
  assign m_data      = mem_q[rd_ptr_q];
  assign m_last      = m_valid && (popped_q == len_q - LEN_W'(1));

endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: behavioural ram, queue-based expected stream
// built from base/len at each accepted start, directed scenarios followed by
// randomized bursts with random backpressure.
module tb_ram_burst_reader;

  localparam int unsigned RamSize = 1024;
  localparam int unsigned LenW    = 11;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [31:0]     base_addr;
  logic [LenW-1:0] len;
  logic            busy, done;
  logic [31:0]     ram_address;
  logic            ram_we;
  logic [31:0]     ram_wr_data;
  logic [31:0]     ram_rd_data;
  logic            m_valid;
  logic [31:0]     m_data;
  logic            m_last;
  logic            m_ready;

  ram_burst_reader #(
    .RAM_SIZE  (RamSize),
    .LEN_W     (LenW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .ram_address(ram_address),
    .ram_we     (ram_we),
    .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [RamSize];
  always @(posedge clk) ram_rd_data <= ram[int'(ram_address % RamSize)];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] exp_q [$];
  bit          pending_done = 1'b0;
  bit          busy_model   = 1'b0;
  int          beat_cnt     = 0;
  int          ready_mode   = 0;  // 0: always ready, 1: random, 2: stall pattern

  // Stream monitor, sampling on the falling edge.
  initial begin
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;
    bit          done_exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        done_exp     = pending_done;
        pending_done = 1'b0;
        if (done_exp) busy_model = 1'b0;
        check("done", {31'b0, done}, {31'b0, done_exp});
        check("busy", {31'b0, busy}, {31'b0, busy_model});
        check("addr_range", {31'b0, ram_address < RamSize}, 32'd1);
        check("ram_we", {31'b0, ram_we}, 32'd0);
        check("ram_wr_data", ram_wr_data, 32'd0);
        if (prev_stall) begin
          check("stall_valid", {31'b0, m_valid}, 32'd1);
          check("stall_data", m_data, prev_data);
          check("stall_last", {31'b0, m_last}, {31'b0, prev_last});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {31'b0, m_valid}, 32'd0);
          end else begin
            check("beat_data", m_data, exp_q[0]);
            check("beat_last", {31'b0, m_last}, {31'b0, exp_q.size() == 1});
            if (exp_q.size() == 1) pending_done = 1'b1;
            void'(exp_q.pop_front());
          end
          beat_cnt++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  // m_ready driver
  initial begin
    int bp = 0;
    int prev_mode = -1;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode != prev_mode) bp = 0;
      prev_mode = ready_mode;
      case (ready_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'($urandom_range(0, 1));
        default: begin
          // 1,0,1,0 then low for 10 cycles, then high
          if (bp < 4) m_ready = (bp % 2 == 0);
          else if (bp < 14) m_ready = 1'b0;
          else m_ready = 1'b1;
          bp++;
        end
      endcase
    end
  end

  // Called just after a rising edge with the DUT idle; returns just after the
  // accepting edge.
  task automatic start_burst(input logic [31:0] b, input int l);
    start     = 1'b1;
    base_addr = b;
    len       = LenW'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < l; i++) exp_q.push_back(ram[int'((b + 32'(i)) % RamSize)]);
    if (l == 0) pending_done = 1'b1;
    else busy_model = 1'b1;
  endtask

  // Returns just after the edge that raised done (inside the done cycle).
  task automatic wait_done();
    int n = 0;
    while (!done && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) check("timeout_done", {31'b0, done}, 32'd1);
  endtask

  initial begin
    int b0;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    for (int i = 0; i < int'(RamSize); i++) ram[i] = 32'h1000 + 32'(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_addr", ram_address, 32'd0);
    check("rst_we", {31'b0, ram_we}, 32'd0);
    check("rst_wr_data", ram_wr_data, 32'd0);
    check("rst_valid", {31'b0, m_valid}, 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_last", {31'b0, m_last}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic burst: latency, consecutive beats, last and done timing.
    start_burst(32'd16, 8);
    check("t1_addr", ram_address, 32'd16);
    check("t1_valid_e0", {31'b0, m_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_e1", {31'b0, m_valid}, 32'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      check("t1_valid", {31'b0, m_valid}, 32'd1);
      check("t1_data", m_data, 32'h1010 + 32'(k));
      check("t1_last", {31'b0, m_last}, {31'b0, k == 7});
      @(posedge clk);
      #1;
    end
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_valid_end", {31'b0, m_valid}, 32'd0);
    wait_done();
    @(posedge clk);
    #1;

    // Address wrap
    start_burst(32'd1022, 4);
    wait_done();
    @(posedge clk);
    #1;

    // Backpressure
    ready_mode = 2;
    start_burst(32'd100, 16);
    wait_done();
    ready_mode = 0;
    @(posedge clk);
    #1;

    // Zero length
    start_burst(32'd5, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("len0_valid", {31'b0, m_valid}, 32'd0);
      check("len0_busy", {31'b0, busy}, 32'd0);
    end

    // Start while busy is ignored
    b0 = beat_cnt;
    start_burst(32'd200, 10);
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 32'd500;
    len       = LenW'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    check("ignore_beats", beat_cnt - b0, 32'd10);
    @(posedge clk);
    #1;

    // Reset mid-burst
    b0 = beat_cnt;
    start_burst(32'd300, 10);
    n = 0;
    while (beat_cnt - b0 < 3 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_mid_beats", beat_cnt - b0, 32'd3);
    rst = 1'b1;
    #1;
    exp_q.delete();
    pending_done = 1'b0;
    busy_model   = 1'b0;
    check("rstm_busy", {31'b0, busy}, 32'd0);
    check("rstm_done", {31'b0, done}, 32'd0);
    check("rstm_addr", ram_address, 32'd0);
    check("rstm_valid", {31'b0, m_valid}, 32'd0);
    check("rstm_data", m_data, 32'd0);
    check("rstm_last", {31'b0, m_last}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    b0 = beat_cnt;
    start_burst(32'd0, 2);
    wait_done();
    check("rst_new_beats", beat_cnt - b0, 32'd2);
    @(posedge clk);
    #1;

    // Back-to-back: second start in the done cycle
    start_burst(32'd40, 5);
    wait_done();
    b0 = beat_cnt;
    start_burst(32'd60, 3);
    wait_done();
    check("b2b_beats", beat_cnt - b0, 32'd3);

    // Randomized bursts with random backpressure and random ram contents
    @(posedge clk);
    #1;
    ready_mode = 1;
    for (int i = 0; i < int'(RamSize); i++) ram[i] = $urandom;
    for (int t = 0; t < 30; t++) begin
      int l;
      l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      start_burst($urandom, l);
      wait_done();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    check("leftover_words", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
